// File: rtl/dac_sample_pacer.sv
// Sample FIFO plus fixed-period pacer feeding the DAC D input.
// Samples are released one per tick; the last code is held and a sticky flag is raised on starvation.
module dac_sample_pacer #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8,
   parameter int DIV_W = 16
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     enable,
   input  logic [DIV_W-1:0]         div,
   input  logic                     clr_flags,
   output logic [WIDTH-1:0]         dac_d,
   output logic                     sample_strobe,
   output logic                     underflow,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [LVL_W-1:0] level_reg, level_next;
   logic [DIV_W-1:0] cnt_reg, cnt_next;
   logic [WIDTH-1:0] dac_d_reg, dac_d_next;
   logic             strobe_reg, strobe_next;
   logic             underflow_reg, underflow_next;

   logic full, empty, push, tick, pop;

   // Full/empty come from the occupancy count, so pointers never need an extra wrap bit.
   assign full  = (level_reg == LVL_W'(DEPTH));
   assign empty = (level_reg == '0);
   assign push  = in_valid & ~full;
   assign tick  = enable & (cnt_reg == '0);
   assign pop   = tick & ~empty;

   always_comb begin
      cnt_next       = cnt_reg;
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      level_next     = level_reg;
      dac_d_next     = dac_d_reg;
      strobe_next    = 1'b0;
      underflow_next = underflow_reg;

      // A new div is only picked up on reload, never mid-countdown.
      if (!enable || cnt_reg == '0) begin
         cnt_next = div;
      end else begin
         cnt_next = cnt_reg - 1'b1;
      end

      if (push) begin
         wr_ptr_next = wr_ptr_reg + 1'b1;
      end

      if (pop) begin
         rd_ptr_next = rd_ptr_reg + 1'b1;
         dac_d_next  = mem[rd_ptr_reg];
         strobe_next = 1'b1;
      end

      case ({push, pop})
         2'b10:   level_next = level_reg + 1'b1;
         2'b01:   level_next = level_reg - 1'b1;
         default: level_next = level_reg;
      endcase

      // Set has priority over clear when both land on the same edge.
      if (clr_flags) begin
         underflow_next = 1'b0;
      end
      if (tick && empty) begin
         underflow_next = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         cnt_reg       <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         dac_d_reg     <= MIDSCALE;
         strobe_reg    <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         cnt_reg       <= cnt_next;
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         level_reg     <= level_next;
         dac_d_reg     <= dac_d_next;
         strobe_reg    <= strobe_next;
         underflow_reg <= underflow_next;
      end
   end

   // Storage carries no reset; stale entries are unreachable once the pointers and level clear.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr_reg] <= in_data;
      end
   end

   assign in_ready      = ~full;
   assign level         = level_reg;
   assign dac_d         = dac_d_reg;
   assign sample_strobe = strobe_reg;
   assign underflow     = underflow_reg;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Directed bench for dac_sample_pacer: pacing, FIFO fill/drain, wrap, flag priority and mid-stream reset.
module tb_dac_sample_pacer;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        enable = 1'b0;
   logic [15:0] div = '0;
   logic        clr_flags = 1'b0;
   logic [9:0]  dac_d;
   logic        sample_strobe;
   logic        underflow;
   logic [3:0]  level;

   int errors = 0;
   int checks = 0;
   int n_acc = 0;
   int strobe_cnt = 0;

   dac_sample_pacer #(.WIDTH(10), .DEPTH(8), .DIV_W(16)) dut (
      .CLK           (CLK),
      .reset         (reset),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .enable        (enable),
      .div           (div),
      .clr_flags     (clr_flags),
      .dac_d         (dac_d),
      .sample_strobe (sample_strobe),
      .underflow     (underflow),
      .level         (level)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one posedge, sampling at the following negedge; counts accepted pushes.
   task automatic step();
      logic will_push;
      will_push = in_valid && in_ready;
      @(negedge CLK);
      if (will_push) n_acc++;
   endtask

   initial begin
      logic [9:0] exp_dac;
      logic       exp_stb;
      logic       exp_uf;

      // Reset and idle
      #1 reset = 1'b0;
      #2;
      check_eq("rst_dac", dac_d, 32'h200);
      check_eq("rst_level", level, 0);
      check_eq("rst_ready", in_ready, 1);
      check_eq("rst_strobe", sample_strobe, 0);
      check_eq("rst_uf", underflow, 0);
      @(negedge CLK);
      @(negedge CLK);
      reset = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         if (sample_strobe) strobe_cnt++;
      end
      check_eq("idle_strobes", strobe_cnt, 0);
      check_eq("idle_dac", dac_d, 32'h200);
      check_eq("idle_level", level, 0);
      check_eq("idle_uf", underflow, 0);
      $display("idle: 100 cycles, strobes=%0d dac_d=0x%0h", strobe_cnt, dac_d);

      // Three samples paced at div=3
      div = 16'd3;
      in_valid = 1'b1;
      in_data = 10'h001; step();
      in_data = 10'h0FF; step();
      in_data = 10'h3FF; step();
      in_valid = 1'b0;
      check_eq("pace_level3", level, 3);
      enable = 1'b1;
      for (int k = 0; k < 16; k++) begin
         step();
         exp_stb = (k == 3 || k == 7 || k == 11);
         exp_dac = (k < 3) ? 10'h200 : (k < 7) ? 10'h001 : (k < 11) ? 10'h0FF : 10'h3FF;
         exp_uf  = (k == 15);
         check_eq($sformatf("pace_strobe_%0d", k), sample_strobe, exp_stb);
         check_eq($sformatf("pace_dac_%0d", k), dac_d, exp_dac);
         check_eq($sformatf("pace_uf_%0d", k), underflow, exp_uf);
         $display("pace k=%0d dac_d=0x%0h strobe=%0b uf=%0b", k, dac_d, sample_strobe, underflow);
      end
      check_eq("pace_level0", level, 0);

      // Flag clear vs. simultaneous underflow tick
      clr_flags = 1'b1; step(); clr_flags = 1'b0;
      check_eq("clr_alone_a", underflow, 0);
      step();
      step();
      clr_flags = 1'b1; step();
      check_eq("clr_vs_tick", underflow, 1);
      check_eq("clr_vs_tick_dac", dac_d, 32'h3FF);
      check_eq("clr_vs_tick_stb", sample_strobe, 0);
      enable = 1'b0;
      step(); clr_flags = 1'b0;
      check_eq("clr_alone_b", underflow, 0);
      $display("flags: set-wins and clear-alone done, uf=%0b", underflow);

      // Fill to full with pacer stopped
      n_acc = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 10'(32'h100 + n_acc);
         step();
      end
      in_data = 10'(32'h100 + n_acc);
      check_eq("fill_accepted", n_acc, 8);
      check_eq("fill_level", level, 8);
      check_eq("fill_ready", in_ready, 0);
      $display("fill: accepted=%0d level=%0d in_ready=%0b", n_acc, level, in_ready);
      div = 16'd0;
      step();
      check_eq("full_hold_level", level, 8);
      enable = 1'b1;
      step();
      enable = 1'b0;
      check_eq("full_pop_dac", dac_d, 32'h100);
      check_eq("full_pop_stb", sample_strobe, 1);
      check_eq("full_pop_level", level, 7);
      in_data = 10'(32'h100 + n_acc);
      step();
      check_eq("ninth_level", level, 8);
      check_eq("ninth_ready", in_ready, 0);
      check_eq("ninth_stb", sample_strobe, 0);
      check_eq("ninth_acc", n_acc, 9);
      $display("ninth word: level=%0d accepted=%0d", level, n_acc);

      // Streaming at div=0 from full, across pointer wrap
      enable = 1'b1;
      for (int j = 0; j < 20; j++) begin
         in_data = 10'(32'h100 + n_acc);
         step();
         check_eq($sformatf("stream_dac_%0d", j), dac_d, 32'h101 + j);
         check_eq($sformatf("stream_stb_%0d", j), sample_strobe, 1);
         check_eq($sformatf("stream_level_%0d", j), level, 7);
         $display("stream j=%0d dac_d=0x%0h level=%0d", j, dac_d, level);
      end
      in_valid = 1'b0;
      enable = 1'b0;
      step();
      check_eq("stream_acc", n_acc, 28);
      check_eq("stream_end_level", level, 7);

      // Reset mid-stream with level=5
      enable = 1'b1;
      step();
      step();
      enable = 1'b0;
      check_eq("pre_rst_level", level, 5);
      check_eq("pre_rst_dac", dac_d, 32'h116);
      check_eq("pre_rst_stb", sample_strobe, 1);
      #2 reset = 1'b0;
      #1;
      check_eq("mid_rst_dac", dac_d, 32'h200);
      check_eq("mid_rst_stb", sample_strobe, 0);
      check_eq("mid_rst_level", level, 0);
      check_eq("mid_rst_ready", in_ready, 1);
      $display("mid-stream reset: dac_d=0x%0h level=%0d", dac_d, level);
      @(negedge CLK);
      reset = 1'b1;
      enable = 1'b1;
      div = 16'd0;
      strobe_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (sample_strobe) strobe_cnt++;
      end
      check_eq("post_rst_strobes", strobe_cnt, 0);
      check_eq("post_rst_dac", dac_d, 32'h200);
      check_eq("post_rst_uf", underflow, 1);
      check_eq("post_rst_level", level, 0);
      in_valid = 1'b1;
      in_data = 10'h055;
      step();
      in_valid = 1'b0;
      check_eq("push_empty_level", level, 1);
      check_eq("push_empty_dac", dac_d, 32'h200);
      check_eq("push_empty_stb", sample_strobe, 0);
      step();
      check_eq("new_word_dac", dac_d, 32'h055);
      check_eq("new_word_stb", sample_strobe, 1);
      check_eq("new_word_level", level, 0);
      step();
      check_eq("new_word_hold", dac_d, 32'h055);
      check_eq("new_word_stb_off", sample_strobe, 0);
      $display("post-reset: dac_d=0x%0h uf=%0b", dac_d, underflow);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
